// File: rtl/spm_arb_pkg.sv
// Shared encodings for the SPM bus arbiter.
// States, read-return owners and bus direction codes.
package spm_arb_pkg;

  typedef enum logic [1:0] {
    S_TEST     = 2'd0,
    S_RUN      = 2'd1,
    S_IF_FORCE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_TST  = 2'd1,
    OWN_IF   = 2'd2,
    OWN_MEM  = 2'd3
  } owner_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/spm_arb_starve_cnt.sv
// Counts consecutive cycles in which a fetch request lost arbitration.
// Holds at STARVE_MAX-1; o_hit reports that ceiling back to the arbiter.
module spm_arb_starve_cnt
  import spm_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_starve_cnt,
  output logic             o_hit
);

  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(STARVE_MAX - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starve_cnt = r_cnt;
  assign o_hit        = (r_cnt == MAX_CNT);

endmodule

// File: rtl/spm_bus_arbiter.sv
// Single-port SPM arbiter: test loader, MEM-stage data and IF fetch.
// One access per cycle; read data returns one cycle later to its issuer.
module spm_bus_arbiter
  import spm_arb_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] tst_addr,
  input  logic              tst_as_,
  input  logic              tst_rw,
  input  logic [DATA_W-1:0] tst_wr_data,
  output logic [DATA_W-1:0] tst_rd_data,
  output logic              tst_rd_valid,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_as_,
  output logic [DATA_W-1:0] if_rd_data,
  output logic              if_rd_valid,
  output logic              if_stall,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_as_,
  input  logic              mem_rw,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_rd_valid,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(STARVE_MAX - 1);

  state_t r_state;
  state_t w_state_nxt;
  owner_t r_rd_owner;
  owner_t w_own_nxt;

  logic w_tst_req;
  logic w_if_req;
  logic w_mem_req;
  logic w_tst_gnt;
  logic w_if_gnt;
  logic w_mem_gnt;
  logic w_if_deny;
  logic w_cnt_clr;
  logic w_sat;
  logic [CNT_W-1:0] w_starve_cnt;

  assign w_tst_req = ~tst_as_;
  assign w_if_req  = ~if_as_;
  assign w_mem_req = ~mem_as_;

  // Grants are held off while reset is asserted so the bus stays idle.
  always_comb begin
    w_tst_gnt = 1'b0;
    w_if_gnt  = 1'b0;
    w_mem_gnt = 1'b0;
    if (reset) begin
      unique case (r_state)
        S_TEST: begin
          w_tst_gnt = w_tst_req;
        end
        S_RUN: begin
          w_mem_gnt = w_mem_req;
          w_if_gnt  = w_if_req & ~w_mem_req;
        end
        S_IF_FORCE: begin
          w_if_gnt  = w_if_req;
          w_mem_gnt = w_mem_req & ~w_if_req;
        end
        default: ;
      endcase
    end
  end

  assign w_if_deny =
    (r_state == S_RUN) & w_if_req & ~w_if_gnt;
  assign w_cnt_clr = ~w_if_deny;

  spm_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk          (clk),
    .reset        (reset),
    .i_inc        (w_if_deny & ~w_sat),
    .i_clr        (w_cnt_clr),
    .o_starve_cnt (w_starve_cnt),
    .o_hit        (w_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_TEST: begin
        if (cpu_en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!cpu_en)
          w_state_nxt = S_TEST;
        else if (w_if_deny &&
                 w_starve_cnt == MAX_CNT)
          w_state_nxt = S_IF_FORCE;
      end
      S_IF_FORCE: begin
        w_state_nxt = cpu_en ? S_RUN : S_TEST;
      end
      default: w_state_nxt = S_TEST;
    endcase
  end

  always_comb begin
    spm_as_     = 1'b1;
    spm_addr    = '0;
    spm_rw      = RW_READ;
    spm_wr_data = '0;
    w_own_nxt   = OWN_NONE;
    unique case (1'b1)
      w_tst_gnt: begin
        spm_as_     = 1'b0;
        spm_addr    = tst_addr;
        spm_rw      = tst_rw;
        spm_wr_data = tst_wr_data;
        if (tst_rw == RW_READ) w_own_nxt = OWN_TST;
      end
      w_if_gnt: begin
        spm_as_   = 1'b0;
        spm_addr  = if_addr;
        spm_rw    = RW_READ;
        w_own_nxt = OWN_IF;
      end
      w_mem_gnt: begin
        spm_as_     = 1'b0;
        spm_addr    = mem_addr;
        spm_rw      = mem_rw;
        spm_wr_data = mem_wr_data;
        if (mem_rw == RW_READ) w_own_nxt = OWN_MEM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_TEST;
      r_rd_owner <= OWN_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_owner <= w_own_nxt;
    end
  end

  assign if_stall  = reset & w_if_req & ~w_if_gnt;
  assign mem_stall = reset & w_mem_req & ~w_mem_gnt;

  assign tst_rd_valid = (r_rd_owner == OWN_TST);
  assign if_rd_valid  = (r_rd_owner == OWN_IF);
  assign mem_rd_valid = (r_rd_owner == OWN_MEM);

  assign tst_rd_data = reset ? spm_rd_data : '0;
  assign if_rd_data  = reset ? spm_rd_data : '0;
  assign mem_rd_data = reset ? spm_rd_data : '0;

endmodule

// File: tb/tb_spm_bus_arbiter.sv
// Bench for spm_bus_arbiter: SPM model, per-cycle reference model,
// and directed scenarios with hand-computed expectations.
module tb_spm_bus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_en;
  logic [AW-1:0] tst_addr;
  logic          tst_as_;
  logic          tst_rw;
  logic [DW-1:0] tst_wr_data;
  logic [DW-1:0] tst_rd_data;
  logic          tst_rd_valid;
  logic [AW-1:0] if_addr;
  logic          if_as_;
  logic [DW-1:0] if_rd_data;
  logic          if_rd_valid;
  logic          if_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_as_;
  logic          mem_rw;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic          mem_stall;
  logic [AW-1:0] spm_addr;
  logic          spm_as_;
  logic          spm_rw;
  logic [DW-1:0] spm_wr_data;
  logic [DW-1:0] spm_rd_data = '0;

  spm_bus_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_en       (cpu_en),
    .tst_addr     (tst_addr),
    .tst_as_      (tst_as_),
    .tst_rw       (tst_rw),
    .tst_wr_data  (tst_wr_data),
    .tst_rd_data  (tst_rd_data),
    .tst_rd_valid (tst_rd_valid),
    .if_addr      (if_addr),
    .if_as_       (if_as_),
    .if_rd_data   (if_rd_data),
    .if_rd_valid  (if_rd_valid),
    .if_stall     (if_stall),
    .mem_addr     (mem_addr),
    .mem_as_      (mem_as_),
    .mem_rw       (mem_rw),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_stall    (mem_stall),
    .spm_addr     (spm_addr),
    .spm_as_      (spm_as_),
    .spm_rw       (spm_rw),
    .spm_wr_data  (spm_wr_data),
    .spm_rd_data  (spm_rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Environment SPM: synchronous read, one-cycle latency.
  logic [DW-1:0] env_mem [64];
  always @(posedge clk) begin
    if (!spm_as_) begin
      if (spm_rw) env_mem[spm_addr[5:0]] <= spm_wr_data;
      else        spm_rd_data <= env_mem[spm_addr[5:0]];
    end
  end

  // Reference model: mode, starvation streak, pending return.
  typedef enum int {MT, MR, MF} mmode_t;
  mmode_t        m_mode   = MT;
  int            m_streak = 0;
  int            m_pend   = 0;
  logic [DW-1:0] m_pdata  = '0;
  logic [DW-1:0] ref_mem [64];

  always @(negedge clk) begin
    logic          gt, gi, gm, eas, erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    if (!reset) begin
      chk("rst_ctl",
          {tst_rd_valid, if_rd_valid, mem_rd_valid,
           if_stall, mem_stall, spm_as_}, 64'b000001);
      chk("rst_bus", {spm_addr, spm_rw, spm_wr_data}, 64'd0);
      chk("rst_rdata",
          {32'd0, tst_rd_data | if_rd_data | mem_rd_data}, 64'd0);
      m_mode = MT; m_streak = 0; m_pend = 0;
    end else begin
      gt = 1'b0; gi = 1'b0; gm = 1'b0;
      if (m_mode == MT) begin
        gt = !tst_as_;
      end else if (m_mode == MR) begin
        gm = !mem_as_;
        gi = !if_as_ && mem_as_;
      end else begin
        gi = !if_as_;
        gm = !mem_as_ && if_as_;
      end
      eas = 1'b1; ea = '0; erw = 1'b0; ewd = '0;
      if (gt) begin
        eas = 1'b0; ea = tst_addr; erw = tst_rw; ewd = tst_wr_data;
      end else if (gi) begin
        eas = 1'b0; ea = if_addr;
      end else if (gm) begin
        eas = 1'b0; ea = mem_addr; erw = mem_rw; ewd = mem_wr_data;
      end
      chk("ctl",
          {tst_rd_valid, if_rd_valid, mem_rd_valid,
           if_stall, mem_stall, spm_as_},
          {m_pend == 1, m_pend == 2, m_pend == 3,
           !if_as_ && !gi, !mem_as_ && !gm, eas});
      chk("bus", {spm_addr, spm_rw, spm_wr_data}, {ea, erw, ewd});
      if (m_pend == 1) chk("tst_rdata", tst_rd_data, m_pdata);
      if (m_pend == 2) chk("if_rdata", if_rd_data, m_pdata);
      if (m_pend == 3) chk("mem_rdata", mem_rd_data, m_pdata);
      m_pend = 0;
      if (!eas && erw) ref_mem[ea[5:0]] = ewd;
      if (!eas && !erw) begin
        m_pend  = gt ? 1 : (gi ? 2 : 3);
        m_pdata = ref_mem[ea[5:0]];
      end
      if (m_mode == MR && !if_as_ && !gi) m_streak++;
      else m_streak = 0;
      if (!cpu_en) m_mode = MT;
      else if (m_mode == MR && m_streak == SM) m_mode = MF;
      else m_mode = MR;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    cpu_en = 1'b0;
    tst_addr = '0; tst_as_ = 1'b1; tst_rw = 1'b0; tst_wr_data = '0;
    if_addr = '0;  if_as_ = 1'b0;
    mem_addr = '0; mem_as_ = 1'b1; mem_rw = 1'b0; mem_wr_data = '0;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_if_stall", if_stall, 0);
    chk("reset_spm_as", spm_as_, 1);
    nxt();
    reset = 1'b1;

    // Test mode write then read; CPU fetch held off.
    tst_as_ = 1'b0; tst_rw = 1'b1; tst_addr = 5;
    tst_wr_data = 32'hDEAD_BEEF; if_addr = 7;
    @(negedge clk);
    chk("t1_if_stall", if_stall, 1);
    nxt();
    tst_rw = 1'b0;
    @(negedge clk);
    nxt();
    tst_as_ = 1'b1;
    @(negedge clk);
    chk("t1_tst_valid", tst_rd_valid, 1);
    chk("t1_tst_data", tst_rd_data, 32'hDEAD_BEEF);
    nxt();
    if_as_ = 1'b1; cpu_en = 1'b1;
    @(negedge clk);
    nxt();

    // Fetch-only stream.
    for (int i = 0; i < 4; i++) begin
      if_as_ = (i == 3);
      if_addr = AW'(i);
      @(negedge clk);
      if (i < 3) chk("t2_if_stall", if_stall, 0);
      if (i > 0) begin
        chk("t2_if_valid", if_rd_valid, 1);
        chk("t2_if_data", if_rd_data, 32'h1000_0000 + i - 1);
      end
      nxt();
    end

    // MEM vs IF conflict.
    mem_as_ = 1'b0; mem_rw = 1'b0; mem_addr = 12;
    if_as_ = 1'b0; if_addr = 3;
    @(negedge clk);
    chk("t3_if_stall", if_stall, 1);
    chk("t3_mem_stall", mem_stall, 0);
    nxt();
    mem_as_ = 1'b1;
    @(negedge clk);
    chk("t3_mem_valid", mem_rd_valid, 1);
    chk("t3_mem_data", mem_rd_data, 32'h1000_000C);
    chk("t3_if_valid", if_rd_valid, 0);
    chk("t3_if_gnt", if_stall, 0);
    nxt();
    if_as_ = 1'b1;
    @(negedge clk);
    chk("t3_if_valid2", if_rd_valid, 1);
    chk("t3_if_data", if_rd_data, 32'h1000_0003);
    nxt();

    // Starvation: four denials then one forced fetch.
    mem_as_ = 1'b0; mem_addr = 20; if_as_ = 1'b0; if_addr = 4;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_if_stall", if_stall, (k % 5) != 4);
      chk("t4_mem_stall", mem_stall, (k % 5) == 4);
      nxt();
    end
    mem_as_ = 1'b1; if_as_ = 1'b1;
    @(negedge clk);
    nxt();

    // Mode switch with a MEM read in flight.
    mem_as_ = 1'b0; mem_rw = 1'b0; mem_addr = 6; cpu_en = 1'b0;
    @(negedge clk);
    chk("t5_mem_stall", mem_stall, 0);
    nxt();
    mem_as_ = 1'b1;
    tst_as_ = 1'b0; tst_rw = 1'b0; tst_addr = 7;
    @(negedge clk);
    chk("t5_mem_valid", mem_rd_valid, 1);
    chk("t5_mem_data", mem_rd_data, 32'h1000_0006);
    chk("t5_spm_as", spm_as_, 0);
    chk("t5_spm_addr", spm_addr, 7);
    nxt();
    tst_as_ = 1'b1;
    @(negedge clk);
    chk("t5_tst_valid", tst_rd_valid, 1);
    chk("t5_tst_data", tst_rd_data, 32'h1000_0007);
    nxt();

    // Reset while an IF return is pending.
    cpu_en = 1'b1;
    @(negedge clk);
    nxt();
    if_as_ = 1'b0; if_addr = 9;
    @(negedge clk);
    chk("t6_if_stall", if_stall, 0);
    nxt();
    if_as_ = 1'b1;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", if_rd_valid, 0);
    @(negedge clk);
    nxt();
    reset = 1'b1;
    if_as_ = 1'b0;
    @(negedge clk);
    chk("t6_test_state", if_stall, 1);
    chk("t6_spm_as", spm_as_, 1);
    nxt();
    @(negedge clk);
    chk("t6_run_state", if_stall, 0);
    nxt();
    if_as_ = 1'b1;
    @(negedge clk);
    nxt();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
